// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit adder built from one 4-bit carry-lookahead slice.
// The slice is applied to one nibble per clock, least significant nibble first.
// Optional build macro CLA_SEQ_OVF_EN adds the ovf output: two's-complement
// overflow, i.e. (carry into the MSB) ^ cout.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE. While out_valid is high, sum/cout (and ovf) are held
// until out_ready is seen. A producer that drops valid before ready is
// simply not served.
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [1:0]       dbg_state
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB_CNT = WIDTH / 4;
  localparam int IDX_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // WIDTH must split evenly into nibbles.
  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Slice signals: the nibble currently selected by idx_q.
  logic [3:0] nib_a, nib_b;
  logic [3:0] slice_g, slice_p;
  logic [3:0] slice_c;   // slice_c[i] is the carry into bit i of the nibble
  logic       slice_c4;  // carry out of the nibble
  logic [3:0] slice_s;

  // 4-bit carry-lookahead slice on the current nibble and the carry register.
  always_comb begin
    nib_a    = a_q[{idx_q, 2'b00} +: 4];
    nib_b    = b_q[{idx_q, 2'b00} +: 4];
    slice_g  = nib_a & nib_b;
    slice_p  = nib_a ^ nib_b;
    slice_c  = '0;
    slice_c[0] = carry_q;
    slice_c[1] = slice_g[0]
               | (slice_p[0] & carry_q);
    slice_c[2] = slice_g[1]
               | (slice_p[1] & slice_g[0])
               | (slice_p[1] & slice_p[0] & carry_q);
    slice_c[3] = slice_g[2]
               | (slice_p[2] & slice_g[1])
               | (slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_c4   = slice_g[3]
               | (slice_p[3] & slice_g[2])
               | (slice_p[3] & slice_p[2] & slice_g[1])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_s  = slice_p ^ slice_c;
  end

  // Next-state and datapath updates for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          idx_d   = '0;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice_s;
        carry_d = slice_c4;
        if (idx_q == LAST_IDX) begin
          // Last nibble: idx stays put so it never runs past the top.
          cout_d  = slice_c4;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = slice_c[3] ^ slice_c4;
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
